// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, parity modes and a
// constant-friendly ceil(log2) helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } rx_state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, bit-period counter and 3-sample majority vote around
// the middle of each bit period.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 56
) (
  input  logic sclk_50M,
  input  logic s_rst,
  input  logic rx,
  input  logic run,
  output logic rx_fall_c,
  output logic bit_tick,
  output logic bit_val
);

  localparam int unsigned CW   = clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  logic          sync1, sync2, sync_prev;
  logic [CW-1:0] cnt;
  logic          s_a, s_b;

  always_ff @(posedge sclk_50M) begin
    if (s_rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_prev <= 1'b1;
      cnt       <= '0;
      s_a       <= 1'b0;
      s_b       <= 1'b0;
    end else begin
      sync1     <= rx;
      sync2     <= sync1;
      sync_prev <= sync2;
      // Counter restarts at each bit boundary and is held at 0 while idle
      if (!run || cnt == CW'(CLKS_PER_BIT - 1)) cnt <= '0;
      else                                      cnt <= cnt + CW'(1);
      if (run && cnt == CW'(HALF - 1)) s_a <= sync2;
      if (run && cnt == CW'(HALF))     s_b <= sync2;
    end
  end

  assign rx_fall_c = sync_prev & ~sync2;
  assign bit_tick  = run && (cnt == CW'(HALF + 1));
  // Third sample is the live synchronised line at the tick
  assign bit_val   = (s_a & s_b) | (s_a & sync2) | (s_b & sync2);

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with valid/ready output, framing and parity
// error flags, and an overrun pulse when a finished word cannot be stored.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 56,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 sclk_50M,
  input  logic                 s_rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned IW = 4;

  rx_state_t            state_q, state_n;
  logic [IW-1:0]        idx_q, idx_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 perr_q, perr_n, ferr_q, ferr_n;
  logic [DATA_BITS-1:0] rx_data_n;
  logic                 rx_valid_n, frame_err_n, parity_err_n, overrun_n;
  logic                 run_c, rx_fall_c, bit_tick, bit_val, done_c;

  assign run_c = (state_q != ST_IDLE);

  uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .sclk_50M (sclk_50M),
    .s_rst    (s_rst),
    .rx       (rx),
    .run      (run_c),
    .rx_fall_c(rx_fall_c),
    .bit_tick (bit_tick),
    .bit_val  (bit_val)
  );

  always_comb begin
    state_n      = state_q;
    idx_n        = idx_q;
    shift_n      = shift_q;
    perr_n       = perr_q;
    ferr_n       = ferr_q;
    rx_data_n    = rx_data;
    rx_valid_n   = rx_valid;
    frame_err_n  = frame_err;
    parity_err_n = parity_err;
    overrun_n    = 1'b0;
    done_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_fall_c) begin
          state_n = ST_START;
          idx_n   = '0;
          perr_n  = 1'b0;
          ferr_n  = 1'b0;
        end
      end
      ST_START: begin
        if (bit_tick) state_n = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_n = {bit_val, shift_q[DATA_BITS-1:1]};
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_n   = '0;
            state_n = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            idx_n = idx_q + IW'(1);
          end
        end
      end
      ST_PAR: begin
        if (bit_tick) begin
          perr_n  = (PARITY == PAR_ODD) ? ~(^shift_q ^ bit_val) : (^shift_q ^ bit_val);
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          ferr_n = ferr_q | ~bit_val;
          // Leave at the mid-sample of the last stop bit to catch a quick next start
          if (idx_q == IW'(STOP_BITS - 1)) begin
            state_n = ST_IDLE;
            done_c  = 1'b1;
          end else begin
            idx_n = idx_q + IW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (rx_valid && rx_ready) rx_valid_n = 1'b0;

    // A held, unaccepted word wins over a newly completed one
    if (done_c) begin
      if (rx_valid && !rx_ready) begin
        overrun_n = 1'b1;
      end else begin
        rx_data_n    = shift_q;
        frame_err_n  = ferr_n;
        parity_err_n = perr_q;
        rx_valid_n   = 1'b1;
      end
    end
  end

  always_ff @(posedge sclk_50M) begin
    if (s_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      shift_q    <= shift_n;
      perr_q     <= perr_n;
      ferr_q     <= ferr_n;
      rx_data    <= rx_data_n;
      rx_valid   <= rx_valid_n;
      frame_err  <= frame_err_n;
      parity_err <= parity_err_n;
      overrun    <= overrun_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default 8N1, even and odd parity, and a
// 5-bit / 2-stop / 16-clock variant, each driven from its own serial line.
module tb_uart_rx_param;

  logic       clk;
  logic       s_rst;
  logic       rx0, rx1, rx2, rx3;
  logic       rdy0, rdy1, rdy2, rdy3;
  logic [7:0] d0, d1, d3;
  logic [4:0] d2;
  logic       v0, v1, v2, v3;
  logic       fe0, fe1, fe2, fe3;
  logic       pe0, pe1, pe2, pe3;
  logic       ov0, ov1, ov2, ov3;

  int          n_cmp, n_fail;
  int          n0, n1, n2, n3, ov0_cnt;
  logic [10:0] last0, last1, last2, last3;

  uart_rx_param dut0 (
    .sclk_50M(clk), .s_rst(s_rst), .rx(rx0), .rx_ready(rdy0), .rx_data(d0),
    .rx_valid(v0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0)
  );

  uart_rx_param #(.PARITY(1)) dut1 (
    .sclk_50M(clk), .s_rst(s_rst), .rx(rx1), .rx_ready(rdy1), .rx_data(d1),
    .rx_valid(v1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1)
  );

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(5), .STOP_BITS(2)) dut2 (
    .sclk_50M(clk), .s_rst(s_rst), .rx(rx2), .rx_ready(rdy2), .rx_data(d2),
    .rx_valid(v2), .frame_err(fe2), .parity_err(pe2), .overrun(ov2)
  );

  uart_rx_param #(.PARITY(2)) dut3 (
    .sclk_50M(clk), .s_rst(s_rst), .rx(rx3), .rx_ready(rdy3), .rx_data(d3),
    .rx_valid(v3), .frame_err(fe3), .parity_err(pe3), .overrun(ov3)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Record every accepted word as {parity_err, frame_err, data}
  always @(negedge clk) begin
    if (v0 && rdy0) begin n0++; last0 = {pe0, fe0, 9'(d0)}; end
    if (v1 && rdy1) begin n1++; last1 = {pe1, fe1, 9'(d1)}; end
    if (v2 && rdy2) begin n2++; last2 = {pe2, fe2, 9'(d2)}; end
    if (v3 && rdy3) begin n3++; last3 = {pe3, fe3, 9'(d3)}; end
    if (ov0) ov0_cnt++;
  end

  function automatic int bt(input int sel);
    return (sel == 2) ? 16 : 56;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0: rx0 = v;
      1: rx1 = v;
      2: rx2 = v;
      default: rx3 = v;
    endcase
  endtask

  task automatic send_bits(input int sel, input logic [15:0] bits, input int len);
    for (int i = 0; i < len; i++) begin
      set_rx(sel, bits[4'(i)]);
      tick(bt(sel));
    end
  endtask

  task automatic send_frame(input int sel, input logic [8:0] d, input int nd,
                            input bit has_par, input logic pbit, input int ns,
                            input logic st0, input logic st1);
    logic [15:0] bits;
    int          len;
    bits    = '1;
    bits[0] = 1'b0;
    len     = 1;
    for (int i = 0; i < nd; i++) begin bits[4'(len)] = d[4'(i)]; len++; end
    if (has_par) begin bits[4'(len)] = pbit; len++; end
    bits[4'(len)] = st0; len++;
    if (ns == 2) begin bits[4'(len)] = st1; len++; end
    send_bits(sel, bits, len);
  endtask

  task automatic idle(input int sel, input int nbits);
    set_rx(sel, 1'b1);
    tick(nbits * bt(sel));
  endtask

  task automatic test_reset;
    s_rst = 1'b1;
    tick(5);
    n_cmp++; if ({v0, v1, v2, v3} !== 4'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0000", {v0, v1, v2, v3}); end
    n_cmp++; if ({fe0, pe0, ov0, fe2, ov2} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {fe0, pe0, ov0, fe2, ov2}); end
    n_cmp++; if ({d0, d1, d2, d3} !== 29'b0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {d0, d1, d2, d3}); end
    s_rst = 1'b0;
    tick(5);
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [4];
    int         b0;
    bytes = '{8'h55, 8'h12, 8'h34, 8'hAA};
    for (int k = 0; k < 4; k++) begin
      b0 = n0;
      send_frame(0, 9'(bytes[k]), 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
      n_cmp++; if (n0 !== b0 + 1) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want %0d", k, n0, b0 + 1); end
      n_cmp++; if (last0 !== {2'b00, 9'(bytes[k])}) begin n_fail++; $display("FAIL b2b_word[%0d]: got %h want %h", k, last0, {2'b00, 9'(bytes[k])}); end
    end
    idle(0, 2);
    n_cmp++; if (ov0_cnt !== 0) begin n_fail++; $display("FAIL b2b_overrun: got %0d want 0", ov0_cnt); end
  endtask

  task automatic test_parity;
    // 0x34 has three ones: even needs parity 1, odd needs parity 0
    send_frame(1, 9'h034, 8, 1'b1, 1'b1, 1, 1'b1, 1'b1); idle(1, 2);
    n_cmp++; if (last1 !== {2'b00, 9'h034}) begin n_fail++; $display("FAIL even_ok: got %h want %h", last1, {2'b00, 9'h034}); end
    send_frame(1, 9'h034, 8, 1'b1, 1'b0, 1, 1'b1, 1'b1); idle(1, 2);
    n_cmp++; if (last1 !== {2'b10, 9'h034}) begin n_fail++; $display("FAIL even_err: got %h want %h", last1, {2'b10, 9'h034}); end
    n_cmp++; if (n1 !== 2) begin n_fail++; $display("FAIL even_count: got %0d want 2", n1); end
    send_frame(3, 9'h034, 8, 1'b1, 1'b0, 1, 1'b1, 1'b1); idle(3, 2);
    n_cmp++; if (last3 !== {2'b00, 9'h034}) begin n_fail++; $display("FAIL odd_ok: got %h want %h", last3, {2'b00, 9'h034}); end
    send_frame(3, 9'h034, 8, 1'b1, 1'b1, 1, 1'b1, 1'b1); idle(3, 2);
    n_cmp++; if (last3 !== {2'b10, 9'h034}) begin n_fail++; $display("FAIL odd_err: got %h want %h", last3, {2'b10, 9'h034}); end
    n_cmp++; if (n3 !== 2) begin n_fail++; $display("FAIL odd_count: got %0d want 2", n3); end
  endtask

  task automatic test_frame_err;
    send_frame(0, 9'h0AA, 8, 1'b0, 1'b0, 1, 1'b0, 1'b1); idle(0, 2);
    n_cmp++; if (last0 !== {2'b01, 9'h0AA}) begin n_fail++; $display("FAIL ferr_word: got %h want %h", last0, {2'b01, 9'h0AA}); end
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1); idle(0, 2);
    n_cmp++; if (last0 !== {2'b00, 9'h055}) begin n_fail++; $display("FAIL ferr_next: got %h want %h", last0, {2'b00, 9'h055}); end
  endtask

  task automatic test_overrun;
    int b0, o0;
    b0 = n0; o0 = ov0_cnt;
    rdy0 = 1'b0;
    send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1); idle(0, 2);
    send_frame(0, 9'h034, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1); idle(0, 2);
    n_cmp++; if ({v0, d0} !== {1'b1, 8'h12}) begin n_fail++; $display("FAIL ovr_held: got %b/%h want 1/12", v0, d0); end
    n_cmp++; if (ov0_cnt !== o0 + 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d want %0d", ov0_cnt, o0 + 1); end
    rdy0 = 1'b1;
    tick(3);
    n_cmp++; if (n0 !== b0 + 1) begin n_fail++; $display("FAIL ovr_count: got %0d want %0d", n0, b0 + 1); end
    n_cmp++; if (last0 !== {2'b00, 9'h012}) begin n_fail++; $display("FAIL ovr_word: got %h want %h", last0, {2'b00, 9'h012}); end
    n_cmp++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL ovr_drop: got %b want 0", v0); end
  endtask

  task automatic test_glitch;
    int b0;
    b0 = n0;
    set_rx(0, 1'b0); tick(10);
    idle(0, 3);
    n_cmp++; if (n0 !== b0 || v0 !== 1'b0) begin n_fail++; $display("FAIL glitch: got count %0d valid %b want %0d/0", n0, v0, b0); end
  endtask

  task automatic test_reset_mid;
    int b0;
    rdy0 = 1'b0;
    send_frame(0, 9'h0AA, 8, 1'b0, 1'b0, 1, 1'b0, 1'b1); idle(0, 2);
    b0 = n0;
    // Start bit plus bits 0..3 of 0x55, then sit in bit 4 (a 1)
    send_bits(0, 16'b0000_0000_0000_1010, 5);
    set_rx(0, 1'b1); tick(20);
    s_rst = 1'b1; tick(2);
    n_cmp++; if ({v0, fe0, pe0, ov0, d0} !== 12'b0) begin n_fail++; $display("FAIL rstmid_out: got %h want 0", {v0, fe0, pe0, ov0, d0}); end
    s_rst = 1'b0; rdy0 = 1'b1;
    idle(0, 3);
    n_cmp++; if (n0 !== b0) begin n_fail++; $display("FAIL rstmid_discard: got %0d want %0d", n0, b0); end
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1); idle(0, 2);
    n_cmp++; if (n0 !== b0 + 1 || last0 !== {2'b00, 9'h055}) begin n_fail++; $display("FAIL rstmid_next: got %0d/%h want %0d/%h", n0, last0, b0 + 1, {2'b00, 9'h055}); end
  endtask

  task automatic test_break;
    int b0;
    b0 = n0;
    set_rx(0, 1'b0); tick(11 * 56);
    n_cmp++; if (last0 !== {2'b01, 9'h000} || n0 !== b0 + 1) begin n_fail++; $display("FAIL break_word: got %h/%0d want %h/%0d", last0, n0, {2'b01, 9'h000}, b0 + 1); end
    tick(20 * 56);
    n_cmp++; if (n0 !== b0 + 1) begin n_fail++; $display("FAIL break_hold: got %0d want %0d", n0, b0 + 1); end
    idle(0, 2);
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1); idle(0, 2);
    n_cmp++; if (last0 !== {2'b00, 9'h055}) begin n_fail++; $display("FAIL break_next: got %h want %h", last0, {2'b00, 9'h055}); end
  endtask

  task automatic test_small;
    send_frame(2, 9'h01F, 5, 1'b0, 1'b0, 2, 1'b1, 1'b1); idle(2, 2);
    n_cmp++; if (last2 !== {2'b00, 9'h01F}) begin n_fail++; $display("FAIL small_ok: got %h want %h", last2, {2'b00, 9'h01F}); end
    send_frame(2, 9'h01F, 5, 1'b0, 1'b0, 2, 1'b1, 1'b0); idle(2, 2);
    n_cmp++; if (last2 !== {2'b01, 9'h01F}) begin n_fail++; $display("FAIL small_stop2: got %h want %h", last2, {2'b01, 9'h01F}); end
    n_cmp++; if (n2 !== 2) begin n_fail++; $display("FAIL small_count: got %0d want 2", n2); end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    n0 = 0; n1 = 0; n2 = 0; n3 = 0; ov0_cnt = 0;
    last0 = '0; last1 = '0; last2 = '0; last3 = '0;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1; rx3 = 1'b1;
    rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1; rdy3 = 1'b1;
    s_rst = 1'b1;
    test_reset;
    test_back_to_back;
    test_parity;
    test_frame_err;
    test_overrun;
    test_glitch;
    test_reset_mid;
    test_break;
    test_small;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
